// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - stage indices, scoreboard entry type and register-match helper
package hazard_pkg;

  localparam int ST_ID    = 0;
  localparam int ST_EX    = 1;
  localparam int ST_MEM   = 2;
  localparam int ST_WB    = 3;
  localparam int FWD_NONE = 0;

  // Register field sized for the widest supported file; narrower AW is zero-extended.
  localparam int RW_MAX = 8;

  typedef struct packed {
    logic              valid;
    logic [RW_MAX-1:0] rw;
    logic              regwr;
    logic              load;
  } sb_entry_t;

  // Register 0 is hardwired, so a write to it never produces a hazard.
  function automatic logic sb_match(input sb_entry_t e, input logic [RW_MAX-1:0] r);
    return e.valid && e.regwr && (e.rw == r) && (r != '0);
  endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// rtl/hz_scoreboard.sv - in-flight destination shift register with flush invalidate and match outputs
module hz_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSTG      = 3,
  parameter int LOAD_DONE = 2,
  parameter int BR_STAGE  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  sb_entry_t         ent_i,
  input  logic              flush_i,
  input  logic [RW_MAX-1:0] rs_i,
  input  logic [RW_MAX-1:0] rt_i,
  output logic [NSTG:1]     match_rs_o,
  output logic [NSTG:1]     match_rt_o,
  output logic [NSTG:1]     busy_o
);

  sb_entry_t sb_q [1:NSTG];
  sb_entry_t sb_d [1:NSTG];

  // Entries younger than the resolving branch are wrong-path and die as they shift.
  always_comb begin
    sb_d[1] = ent_i;
    for (int s = 2; s <= NSTG; s++) begin
      sb_d[s] = sb_q[s-1];
      if (flush_i && ((s - 1) < BR_STAGE)) sb_d[s].valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int s = 1; s <= NSTG; s++) begin
      if (!rst_ni) sb_q[s] <= '0;
      else         sb_q[s] <= sb_d[s];
    end
  end

  // busy marks a load whose data is not yet forwardable from its current stage.
  always_comb begin
    match_rs_o = '0;
    match_rt_o = '0;
    busy_o     = '0;
    for (int s = 1; s <= NSTG; s++) begin
      match_rs_o[s] = sb_match(sb_q[s], rs_i);
      match_rt_o[s] = sb_match(sb_q[s], rt_i);
      busy_o[s]     = sb_q[s].load && (s < LOAD_DONE);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, branch flush and registered EX forwarding selects
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int  AW        = 5,
  parameter int  NFWD      = 2,
  parameter int  LOAD_DONE = 2,
  parameter int  BR_STAGE  = 2,
  localparam int FW        = $clog2(NFWD + 1),
  localparam int NSTG      = NFWD + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [AW-1:0] id_rw,
  input  logic          id_regwr,
  input  logic          id_load,
  input  logic          redirect,
  output logic          stall,
  output logic          bubble,
  output logic          flush,
  output logic [FW-1:0] fwd_a,
  output logic [FW-1:0] fwd_b
);

  logic [RW_MAX-1:0] rs_x, rt_x;
  sb_entry_t         ent;
  logic [NSTG:1]     m_rs, m_rt, busy;
  logic              lu_hit;
  logic [FW-1:0]     sel_a, sel_b;
  logic [FW-1:0]     fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;

  assign rs_x = RW_MAX'(id_rs);
  assign rt_x = RW_MAX'(id_rt);

  hz_scoreboard #(
    .NSTG      (NSTG),
    .LOAD_DONE (LOAD_DONE),
    .BR_STAGE  (BR_STAGE)
  ) u_sb (
    .clk_i      (clk),
    .rst_ni     (rst),
    .ent_i      (ent),
    .flush_i    (flush),
    .rs_i       (rs_x),
    .rt_i       (rt_x),
    .match_rs_o (m_rs),
    .match_rt_o (m_rt),
    .busy_o     (busy)
  );

  always_comb begin
    lu_hit = 1'b0;
    for (int s = ST_EX; s <= NSTG; s++) begin
      if (busy[s] && ((id_use_rs && m_rs[s]) || (id_use_rt && m_rt[s]))) lu_hit = 1'b1;
    end
  end

  // A redirect kills the ID instruction, so it must not also be held.
  assign flush  = redirect;
  assign stall  = id_valid && lu_hit && !redirect;
  assign bubble = stall;

  always_comb begin
    ent       = '0;
    ent.valid = id_valid && !stall && !flush;
    ent.rw    = RW_MAX'(id_rw);
    ent.regwr = id_regwr;
    ent.load  = id_load;
  end

  // Walk oldest to youngest so the youngest producer wins.
  always_comb begin
    sel_a = FW'(FWD_NONE);
    sel_b = FW'(FWD_NONE);
    for (int s = NFWD; s >= ST_EX; s--) begin
      if (m_rs[s]) sel_a = FW'(s);
      if (m_rt[s]) sel_b = FW'(s);
    end
    fwd_a_d = (id_valid && id_use_rs && !stall && !flush) ? sel_a : FW'(FWD_NONE);
    fwd_b_d = (id_valid && id_use_rt && !stall && !flush) ? sel_b : FW'(FWD_NONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fwd_a_q <= '0;
      fwd_b_q <= '0;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven bench with forwarding scoreboard queue and NFWD=3 load case
module tb_hazard_ctrl;

  typedef struct {
    logic       rstn;
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] rw;
    logic       wr;
    logic       ld;
    logic       rd;
    logic       e_st;
    logic       e_fl;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
  } vec_t;

  logic       clk;
  logic       rst, id_valid, id_use_rs, id_use_rt, id_regwr, id_load, redirect;
  logic [4:0] id_rs, id_rt, id_rw;
  logic       stall, bubble, flush;
  logic [1:0] fwd_a, fwd_b;

  logic       b_rst, b_valid, b_use_rs, b_use_rt, b_regwr, b_load, b_redirect;
  logic [4:0] b_rs, b_rt, b_rw;
  logic       b_stall, b_bubble, b_flush;
  logic [1:0] b_fwd_a, b_fwd_b;

  int n_chk  = 0;
  int n_pass = 0;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];

  int st3[5] = '{0, 1, 1, 0, 0};
  int fw3[5] = '{0, 0, 0, 0, 3};

  hazard_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_rw     (id_rw),
    .id_regwr  (id_regwr),
    .id_load   (id_load),
    .redirect  (redirect),
    .stall     (stall),
    .bubble    (bubble),
    .flush     (flush),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b)
  );

  hazard_ctrl #(.NFWD(3), .LOAD_DONE(3)) dut3 (
    .clk       (clk),
    .rst       (b_rst),
    .id_valid  (b_valid),
    .id_rs     (b_rs),
    .id_rt     (b_rt),
    .id_use_rs (b_use_rs),
    .id_use_rt (b_use_rt),
    .id_rw     (b_rw),
    .id_regwr  (b_regwr),
    .id_load   (b_load),
    .redirect  (b_redirect),
    .stall     (b_stall),
    .bubble    (b_bubble),
    .flush     (b_flush),
    .fwd_a     (b_fwd_a),
    .fwd_b     (b_fwd_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
  endtask

  function automatic vec_t mk(input int rn, input int v, input int rs, input int rt,
                              input int urs, input int urt, input int rw, input int wr,
                              input int ld, input int rd, input int st, input int fl,
                              input int fa, input int fb);
    vec_t r;
    r.rstn = 1'(rn); r.v = 1'(v); r.rs = 5'(rs); r.rt = 5'(rt);
    r.urs = 1'(urs); r.urt = 1'(urt); r.rw = 5'(rw); r.wr = 1'(wr);
    r.ld = 1'(ld); r.rd = 1'(rd); r.e_st = 1'(st); r.e_fl = 1'(fl);
    r.e_fa = 2'(fa); r.e_fb = 2'(fb);
    return r;
  endfunction

  // Drive one ID cycle, check same-cycle controls, and check the selects of the previous row.
  task automatic apply(input int idx, input vec_t v);
    logic [3:0] e;
    rst = v.rstn; id_valid = v.v; id_rs = v.rs; id_rt = v.rt;
    id_use_rs = v.urs; id_use_rt = v.urt; id_rw = v.rw;
    id_regwr = v.wr; id_load = v.ld; redirect = v.rd;
    @(negedge clk);
    chk("stall", idx, int'(stall), int'(v.e_st));
    chk("bubble", idx, int'(bubble), int'(v.e_st));
    chk("flush", idx, int'(flush), int'(v.e_fl));
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL fwd_queue[%0d]: got empty expected entry", idx);
    end else begin
      e = exp_q.pop_front();
      chk("fwd_a", idx, int'(fwd_a), int'(e[3:2]));
      chk("fwd_b", idx, int'(fwd_b), int'(e[1:0]));
    end
    exp_q.push_back({v.e_fa, v.e_fb});
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_rw = '0; id_regwr = 1'b0; id_load = 1'b0; redirect = 1'b0;
    b_rst = 1'b0; b_valid = 1'b0; b_rs = '0; b_rt = '0; b_use_rs = 1'b0; b_use_rt = 1'b0;
    b_rw = '0; b_regwr = 1'b0; b_load = 1'b0; b_redirect = 1'b0;

    //                rn v  rs rt us ut rw wr ld rd  st fl fa fb
    vecs.push_back(mk(1, 1,  1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  3, 5, 1, 1, 4, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  4, 3, 1, 1, 6, 1, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 1,  1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  3, 3, 1, 1, 4, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1,  3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 2, 2));
    vecs.push_back(mk(1, 1,  4, 6, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1,  0, 4, 1, 1, 5, 1, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 1,  1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  1, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  6, 0, 1, 0, 7, 1, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1,  6, 7, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  3, 8, 1, 1, 9, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1,  3, 8, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 10, 10, 0, 1, 11, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 11, 0, 1, 0, 12, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 12, 0, 1, 0, 13, 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 12, 0, 1, 0, 13, 1, 1, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 1, 13, 12, 1, 1, 14, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 13, 12, 1, 1, 14, 1, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 14, 0, 1, 0, 15, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 15, 14, 1, 1, 16, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  1, 0, 1, 0, 20, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  1, 0, 1, 0, 21, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  1, 0, 1, 0, 22, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 21, 22, 1, 1, 23, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 22, 21, 1, 1, 24, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  1, 0, 1, 0, 25, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 25, 24, 1, 1, 26, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 0, int'(stall), 0);
    chk("rst_flush", 0, int'(flush), 0);
    chk("rst_fwd_a", 0, int'(fwd_a), 0);
    chk("rst_fwd_b", 0, int'(fwd_b), 0);
    @(posedge clk);
    #1;

    exp_q.push_back(4'h0);
    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Deeper pipeline: load data forwardable only after stage 3, so two stall cycles.
    b_rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      b_valid  = (c < 4);
      b_rs     = (c == 0) ? 5'd1 : 5'd3;
      b_rt     = 5'd3;
      b_use_rs = 1'b1;
      b_use_rt = (c != 0);
      b_rw     = (c == 0) ? 5'd3 : 5'd4;
      b_regwr  = 1'b1;
      b_load   = (c == 0);
      @(negedge clk);
      chk("d3_stall", c, int'(b_stall), st3[c]);
      chk("d3_bubble", c, int'(b_bubble), st3[c]);
      chk("d3_flush", c, int'(b_flush), 0);
      chk("d3_fwd_a", c, int'(b_fwd_a), fw3[c]);
      chk("d3_fwd_b", c, int'(b_fwd_b), fw3[c]);
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
